// File: rtl/ko4_mul_seq.sv
// Sequencer for the KO4 multiplier: splits one DATA_WIDTH x DATA_WIDTH multiply into the
// 9 two-level Karatsuba sub-products, issues them to a shared multiplier and recombines them.
module ko4_mul_seq #(
  parameter int DATA_WIDTH   = 72,
  parameter int KO_PARAMETER = 4,
  parameter int MUL_LAT      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        a,
  input  logic [DATA_WIDTH-1:0]        b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*DATA_WIDTH-1:0]      product,
  output logic                         sm_valid,
  output logic [DATA_WIDTH/KO_PARAMETER+1:0]   sm_a,
  output logic [DATA_WIDTH/KO_PARAMETER+1:0]   sm_b,
  input  logic                         sm_p_valid,
  input  logic [2*(DATA_WIDTH/KO_PARAMETER)+3:0] sm_p
);

  localparam int LIMB = DATA_WIDTH / KO_PARAMETER;
  localparam int OPW  = LIMB + 2;
  localparam int ACCW = 2 * DATA_WIDTH;
  localparam int FW   = $clog2(MUL_LAT + 2);

  typedef enum logic [2:0] {FLUSH, IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                 state_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   sm_valid_q;
  logic [OPW-1:0]         sm_a_q;
  logic [OPW-1:0]         sm_b_q;
  logic [ACCW-1:0]        product_q;
  logic [ACCW-1:0]        acc_q;
  logic [ACCW-1:0]        acc_d;
  logic [DATA_WIDTH-1:0]  a_q;
  logic [DATA_WIDTH-1:0]  b_q;
  logic [3:0]             icnt_q;
  logic [3:0]             rcnt_q;
  logic [FW-1:0]          flush_cnt_q;
  logic                   ret_ok;
  logic [6:0]             pmask;
  logic [6:0]             nmask;
  logic [ACCW-1:0]        sp_ext;
  logic [ACCW-1:0]        term [7];

  // Operand k of the issue sequence: single limbs or exact limb sums.
  function automatic logic [OPW-1:0] limb_sum(input logic [DATA_WIDTH-1:0] x, input logic [3:0] k);
    logic [OPW-1:0] l0, l1, l2, l3;
    l0 = OPW'(x[LIMB-1:0]);
    l1 = OPW'(x[2*LIMB-1:LIMB]);
    l2 = OPW'(x[3*LIMB-1:2*LIMB]);
    l3 = OPW'(x[4*LIMB-1:3*LIMB]);
    case (k)
      4'd0:    return l0;
      4'd1:    return l1;
      4'd2:    return l0 + l1;
      4'd3:    return l2;
      4'd4:    return l3;
      4'd5:    return l2 + l3;
      4'd6:    return l0 + l2;
      4'd7:    return l1 + l3;
      4'd8:    return l0 + l1 + l2 + l3;
      default: return '0;
    endcase
  endfunction

  // Weight w_k expanded over shifts 0..6 limbs: bit j set means +/- (sm_p << j*LIMB).
  function automatic logic [6:0] pos_mask(input logic [3:0] k);
    case (k)
      4'd0:    return 7'b0001001;
      4'd1:    return 7'b0001100;
      4'd2:    return 7'b0000010;
      4'd3:    return 7'b0011000;
      4'd4:    return 7'b1001000;
      4'd5:    return 7'b0100000;
      4'd6:    return 7'b0000100;
      4'd7:    return 7'b0010000;
      4'd8:    return 7'b0001000;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] neg_mask(input logic [3:0] k);
    case (k)
      4'd0:    return 7'b0000110;
      4'd1:    return 7'b0010010;
      4'd2:    return 7'b0001000;
      4'd3:    return 7'b0100100;
      4'd4:    return 7'b0110000;
      4'd5:    return 7'b0001000;
      4'd6:    return 7'b0001000;
      4'd7:    return 7'b0001000;
      default: return 7'b0000000;
    endcase
  endfunction

  assign ret_ok = sm_p_valid && (state_q == ISSUE || state_q == DRAIN) && (rcnt_q < icnt_q);
  assign pmask  = pos_mask(rcnt_q);
  assign nmask  = neg_mask(rcnt_q);
  assign sp_ext = ACCW'(sm_p);

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_term
      logic [ACCW-1:0] sh;
      assign sh       = sp_ext << (gi * LIMB);
      assign term[gi] = pmask[gi] ? sh : (nmask[gi] ? (~sh + ACCW'(1)) : '0);
    end
  endgenerate

  // Partial sums may wrap; only the final accumulated value is exact.
  always_comb begin
    acc_d = acc_q;
    for (int j = 0; j < 7; j++) begin
      acc_d = acc_d + term[j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FLUSH;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sm_valid_q  <= 1'b0;
      sm_a_q      <= '0;
      sm_b_q      <= '0;
      product_q   <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      icnt_q      <= '0;
      rcnt_q      <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (ret_ok) begin
        acc_q  <= acc_d;
        rcnt_q <= rcnt_q + 4'd1;
      end
      case (state_q)
        FLUSH: begin
          if (flush_cnt_q == FW'(MUL_LAT)) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q + FW'(1);
          end
        end
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            acc_q      <= '0;
            icnt_q     <= '0;
            rcnt_q     <= '0;
            in_ready_q <= 1'b0;
            sm_valid_q <= 1'b1;
            sm_a_q     <= limb_sum(a, 4'd0);
            sm_b_q     <= limb_sum(b, 4'd0);
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          icnt_q <= icnt_q + 4'd1;
          if (icnt_q == 4'd8) begin
            sm_valid_q <= 1'b0;
            sm_a_q     <= '0;
            sm_b_q     <= '0;
            state_q    <= DRAIN;
          end else begin
            sm_a_q <= limb_sum(a_q, icnt_q + 4'd1);
            sm_b_q <= limb_sum(b_q, icnt_q + 4'd1);
          end
        end
        DRAIN: begin
          // Leave on the edge that absorbs the ninth return so out_valid is not delayed a cycle.
          if (ret_ok && rcnt_q == 4'd8) begin
            product_q   <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= FLUSH;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign sm_valid  = sm_valid_q;
  assign sm_a      = sm_a_q;
  assign sm_b      = sm_b_q;

endmodule

// File: tb/tb_ko4_mul_seq.sv
// Bench for ko4_mul_seq: plays the shared limb multiplier with a queue model and
// compares every product against direct wide multiplication.
module tb_ko4_mul_seq;
  localparam int DW      = 72;
  localparam int LIMB    = 18;
  localparam int OPW     = LIMB + 2;
  localparam int PW      = 2 * LIMB + 4;
  localparam int PRW     = 2 * DW;
  localparam int DUT_LAT = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [DW-1:0]  a = '0;
  logic [DW-1:0]  b = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [PRW-1:0] product;
  logic           sm_valid;
  logic [OPW-1:0] sm_a;
  logic [OPW-1:0] sm_b;
  logic           sm_p_valid = 1'b0;
  logic [PW-1:0]  sm_p = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int model_lat = 2;
  bit inject_stale = 1'b0;

  typedef struct {
    int            due;
    logic [PW-1:0] p;
  } ret_t;
  ret_t           pipe[$];
  logic [OPW-1:0] ia_log[$];
  logic [OPW-1:0] ib_log[$];

  ko4_mul_seq #(.DATA_WIDTH(DW), .KO_PARAMETER(4), .MUL_LAT(DUT_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .sm_valid(sm_valid), .sm_a(sm_a), .sm_b(sm_b),
    .sm_p_valid(sm_p_valid), .sm_p(sm_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared multiplier: an issue seen before edge cyc+1 returns before edge cyc+1+model_lat.
  always @(negedge clk) begin
    if (sm_valid) begin
      pipe.push_back('{cyc + 1 + model_lat, PW'(sm_a) * PW'(sm_b)});
      ia_log.push_back(sm_a);
      ib_log.push_back(sm_b);
    end
    sm_p_valid = 1'b0;
    sm_p = '0;
    if (pipe.size() > 0 && pipe[0].due == cyc + 1) begin
      sm_p_valid = 1'b1;
      sm_p = pipe[0].p;
      void'(pipe.pop_front());
    end
    if (inject_stale) begin
      sm_p_valid = 1'b1;
      sm_p = PW'({$urandom, $urandom});
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: sim time expired, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] rand72();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic run_mul(input logic [DW-1:0] x, input logic [DW-1:0] y, input int lat,
                         output logic [PRW-1:0] p, output int lat_cyc, output int pulses,
                         output int waits);
    int n;
    p = '0; lat_cyc = -1; pulses = 0; waits = 0;
    model_lat = lat;
    a = x; b = y; in_valid = 1'b1;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      if (sm_valid) pulses++;
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL result_timeout: out_valid=%0b required 1", out_valid);
      return;
    end
    lat_cyc = n;
    p = product;
  endtask

  task automatic check_flush(input string tag);
    for (int i = 0; i <= DUT_LAT; i++) begin
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_flush_ready: cycle %0d in_ready=%0b required 0", tag, i, in_ready);
      end
      @(negedge clk);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_idle_ready: in_ready=%0b required 1", tag, in_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, sm_valid} !== 3'b000 || product !== '0 || sm_a !== '0 || sm_b !== '0) begin
      n_fail++;
      $display("FAIL reset_values: ready=%0b ovalid=%0b smvalid=%0b product=%h sm_a=%h sm_b=%h required all 0",
               in_ready, out_valid, sm_valid, product, sm_a, sm_b);
    end
    rst = 1'b0;
    check_flush("reset");
    $display("reset: flush complete, in_ready=%0b", in_ready);
  endtask

  task automatic test_basic();
    logic [PRW-1:0] p;
    int lc, pu, w;
    out_ready = 1'b1;
    run_mul(72'd1, 72'd1, 2, p, lc, pu, w);
    n_checks++;
    if (p !== PRW'(1)) begin n_fail++; $display("FAIL basic_product: got %h required 1", p); end
    n_checks++;
    if (lc !== 10 + DUT_LAT) begin n_fail++; $display("FAIL basic_latency: got %0d required %0d", lc, 10 + DUT_LAT); end
    n_checks++;
    if (pu !== 9) begin n_fail++; $display("FAIL basic_pulses: got %0d required 9", pu); end
    $display("basic: 1*1 product=%h latency=%0d pulses=%0d", p, lc, pu);
  endtask

  task automatic test_issue_order();
    logic [DW-1:0]  x, y;
    logic [PRW-1:0] p, exp;
    int lc, pu, w;
    int ea[9], eb[9];
    ea = '{1, 2, 3, 3, 4, 7, 4, 6, 10};
    eb = '{5, 6, 11, 7, 8, 15, 12, 14, 26};
    x = {18'd4, 18'd3, 18'd2, 18'd1};
    y = {18'd8, 18'd7, 18'd6, 18'd5};
    exp = PRW'(x) * PRW'(y);
    ia_log.delete(); ib_log.delete();
    run_mul(x, y, 2, p, lc, pu, w);
    n_checks++;
    if (ia_log.size() != 9) begin
      n_fail++;
      $display("FAIL order_count: got %0d issues required 9", ia_log.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        n_checks++;
        if (ia_log[k] !== OPW'(ea[k]) || ib_log[k] !== OPW'(eb[k])) begin
          n_fail++;
          $display("FAIL order_k%0d: got (%0d,%0d) required (%0d,%0d)", k, ia_log[k], ib_log[k], ea[k], eb[k]);
        end
      end
    end
    n_checks++;
    if (p !== exp) begin n_fail++; $display("FAIL order_product: got %h required %h", p, exp); end
    $display("issue_order: product=%h", p);
  endtask

  task automatic test_all_ones();
    logic [PRW-1:0] p, exp;
    int lc, pu, w;
    exp = ~PRW'(0) - (PRW'(1) << 73) + PRW'(2);
    run_mul(~72'd0, ~72'd0, 2, p, lc, pu, w);
    n_checks++;
    if (p !== exp) begin n_fail++; $display("FAIL all_ones: got %h required %h", p, exp); end
    $display("all_ones: product=%h", p);
  endtask

  task automatic test_random();
    logic [DW-1:0]  x, y;
    logic [PRW-1:0] p, exp;
    int lc, pu, w, lat;
    int lats[3];
    lats = '{1, 2, 5};
    for (int i = 0; i < 1000; i++) begin
      lat = lats[i % 3];
      case (i % 50)
        0:       begin x = '0;      y = rand72(); end
        1:       begin x = ~72'd0;  y = rand72(); end
        default: begin x = rand72(); y = rand72(); end
      endcase
      exp = PRW'(x) * PRW'(y);
      run_mul(x, y, lat, p, lc, pu, w);
      n_checks++;
      if (p !== exp) begin
        n_fail++;
        $display("FAIL random_product[%0d]: a=%h b=%h lat=%0d got %h required %h", i, x, y, lat, p, exp);
      end
      n_checks++;
      if (lc !== 10 + lat) begin
        n_fail++;
        $display("FAIL random_latency[%0d]: lat=%0d got %0d required %0d", i, lat, lc, 10 + lat);
      end
      $display("random[%0d]: lat=%0d a=%h b=%h product=%h", i, lat, x, y, p);
    end
    model_lat = 2;
  endtask

  task automatic test_back_to_back();
    logic [PRW-1:0] p;
    int lc, pu, w;
    run_mul(72'd7, 72'd9, 2, p, lc, pu, w);
    run_mul(72'd11, 72'd13, 2, p, lc, pu, w);
    n_checks++;
    if (w !== 1) begin n_fail++; $display("FAIL b2b_accept_gap: got %0d cycles required 1", w); end
    n_checks++;
    if (p !== PRW'(143)) begin n_fail++; $display("FAIL b2b_product: got %h required 143", p); end
    $display("back_to_back: gap=%0d product=%0d", w, p);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0]  x, y;
    logic [PRW-1:0] p, exp;
    int lc, pu, w;
    x = rand72(); y = rand72();
    exp = PRW'(x) * PRW'(y);
    @(negedge clk);
    out_ready = 1'b0;
    run_mul(x, y, 2, p, lc, pu, w);
    n_checks++;
    if (p !== exp) begin n_fail++; $display("FAIL bp_product: got %h required %h", p, exp); end
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || product !== exp || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: ovalid=%0b ready=%0b product=%h required 1,0,%h",
                 i, out_valid, in_ready, product, exp);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: ovalid=%0b ready=%0b required 0,1", out_valid, in_ready);
    end
    $display("backpressure: product=%h held 5 cycles", p);
  endtask

  task automatic test_reset_mid();
    logic [PRW-1:0] p;
    int lc, pu, w;
    model_lat = 2;
    a = rand72(); b = rand72(); in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    n_checks++;
    if (sm_valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_drain_state: smvalid=%0b ovalid=%0b ready=%0b required 0,0,0", sm_valid, out_valid, in_ready);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, sm_valid} !== 3'b000 || product !== '0 || sm_a !== '0 || sm_b !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_values: ready=%0b ovalid=%0b smvalid=%0b product=%h required all 0",
               in_ready, out_valid, sm_valid, product);
    end
    inject_stale = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_flush("mid");
    inject_stale = 1'b0;
    run_mul(72'd3, 72'd5, 2, p, lc, pu, w);
    n_checks++;
    if (p !== PRW'(15)) begin n_fail++; $display("FAIL mid_next_product: got %h required 15", p); end
    $display("reset_mid: next product=%0d", p);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_issue_order();
    test_all_ones();
    test_back_to_back();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ko4_mul_seq.md
Name: ko4_mul_seq

Overview:
- Sequencing controller for the KO4 multiplier datapath.
- Accepts one DATA_WIDTH x DATA_WIDTH unsigned multiply and splits each operand into 4 limbs, a0..a3 and b0..b3, with a0 the least significant.
- Time-multiplexes the 9 two-level Karatsuba sub-products onto one shared, externally pipelined limb multiplier.
- Recombines the returned sub-products into the 2*DATA_WIDTH-bit product and returns it over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 72, operand width; must be divisible by 4.
- KO_PARAMETER, 4, split factor; only 4 is supported.
- MUL_LAT, 2, shared multiplier latency in cycles, from sm_valid to sm_p_valid; must be >= 1.
- LIMB (local), DATA_WIDTH/KO_PARAMETER, limb width (18).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept an operand pair
- a  in  DATA_WIDTH  multiplicand
- b  in  DATA_WIDTH  multiplier
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts the product
- product  out  2*DATA_WIDTH  a*b
- sm_valid  out  1  issue one sub-multiply
- sm_a  out  LIMB+2  sub-multiply operand A, zero-extended
- sm_b  out  LIMB+2  sub-multiply operand B, zero-extended
- sm_p_valid  in  1  sub-product return strobe, in issue order
- sm_p  in  2*LIMB+4  sub-product

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=FLUSH; in_ready=0; out_valid=0; sm_valid=0; sm_a=0; sm_b=0; product=0; accumulator=0; all counters=0.
- Definitions: t = 2^LIMB, T = 2^(2*LIMB).
- Issue order k=0..8, written as (sm_a operand, sm_b operand, weight w_k):
  - k0: (a0, b0, (1-t)(1-T))
  - k1: (a1, b1, (t^2-t)(1-T))
  - k2: (a0+a1, b0+b1, t(1-T))
  - k3: (a2, b2, (1-t)(T^2-T))
  - k4: (a3, b3, (t^2-t)(T^2-T))
  - k5: (a2+a3, b2+b3, t(T^2-T))
  - k6: (a0+a2, b0+b2, (1-t)T)
  - k7: (a1+a3, b1+b3, (t^2-t)T)
  - k8: (a0+a1+a2+a3, b0+b1+b2+b3, tT)
- Arithmetic: limb sums are exact in LIMB+2 bits.
  - Each returned sm_p is added into a 2*DATA_WIDTH-bit accumulator as sm_p*w_k, modulo 2^(2*DATA_WIDTH).
  - Weights expand to signed shift-adds (shifts by 0, LIMB, 2LIMB, 3LIMB, 4LIMB, 5LIMB, 6LIMB).
  - Intermediate values may wrap; the final value equals a*b exactly.
- State machine:
  - FLUSH: in_ready=0 for MUL_LAT+1 cycles after reset deassert, so stale returns drain. Then go to IDLE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a and b, clear the accumulator and both counters, go to ISSUE.
  - ISSUE: sm_valid=1 for 9 consecutive cycles, issuing k=0..8 from counter icnt. After k=8, go to DRAIN.
  - DRAIN: wait until the return counter rcnt reaches 9, then go to DONE.
  - DONE: out_valid=1, product = accumulator, held stable until out_ready. On out_valid&&out_ready, go to IDLE.
- Return handling:
  - sm_p_valid is accepted only in ISSUE or DRAIN while rcnt < icnt; weight is w_rcnt, then rcnt increments.
  - sm_p_valid is ignored in FLUSH, IDLE and DONE.
- Latency: accept at cycle 0. Issues occur at cycles 1..9. Returns occur at cycles 1+MUL_LAT..9+MUL_LAT. out_valid rises at cycle 10+MUL_LAT (12 at default).
- Throughput: one multiply in flight; in_ready=0 outside IDLE. The next accept can occur the cycle after the product handshake.
- out_ready may be high before out_valid; no combinational path from in_valid to out_valid.
- Reset mid-operation: all state is cleared immediately and the in-flight result is discarded. Late sub-product returns during FLUSH are dropped.
- product changes only on entry to DONE.

Test Plan:
- Basic multiply: a=1, b=1 -> product=1 at cycle 12 after accept (MUL_LAT=2). Exactly 9 sm_valid pulses.
- Issue order: limbs a0..a3 = 1,2,3,4 and b0..b3 = 5,6,7,8 -> sm_a sequence 1,2,3,3,4,7,4,6,10 and sm_b sequence 5,6,11,7,8,15,12,14,26. product = a*b from the golden model.
- All-ones: a=b=2^72-1 -> product = 2^144 - 2^73 + 1, i.e. 0xFFFF...FE000...001 with 72 high ones except bit0 of the upper half.
- Random: 1000 random a,b with a golden multiplier model. Vary MUL_LAT over 1, 2, 5 -> exact match every time.
- Backpressure: out_ready=0 for 5 cycles in DONE -> product and out_valid stable, in_ready=0. Handshake on cycle 6, then in_ready=1 the next cycle.
- Reset mid-operation: assert rst during DRAIN -> outputs go to reset values at once. in_ready stays 0 for MUL_LAT+1 cycles after release; injected stale sm_p_valid is ignored. The following multiply (a=3, b=5) gives 15.
